// File: rtl/dest_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dest_scoreboard_pkg
//  Description : Shared defaults and helpers for the destination scoreboard
//                and the register file (address width, register count,
//                address-to-one-hot decode).
//  Revision    : 1.0  initial release
// ============================================================================
package dest_scoreboard_pkg;

    localparam int c_ADDR_W_DEF = 4;
    localparam int c_NREG_DEF   = 1 << c_ADDR_W_DEF;

    // Widest register file the decode helper supports; callers truncate the
    // result to their own NREG.
    localparam int c_MAX_ADDR_W = 10;
    localparam int c_MAX_NREG   = 1 << c_MAX_ADDR_W;

    typedef logic [c_MAX_NREG-1:0] onehot_max_t;

    // Address to one-hot write-enable.
    function automatic onehot_max_t onehot_dec(input logic [c_MAX_ADDR_W-1:0] addr);
        onehot_max_t v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dest_scoreboard_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_nreg
//  Description : Parametrised combinational population count.
//  Ports       : vec   in  N      bit vector to count
//                count out OUT_W  number of set bits in vec
//  Revision    : 1.0  initial release
// ============================================================================
module popcount_nreg #(
    parameter int N     = 16,
    parameter int OUT_W = 5
) (
    input  logic [N-1:0]     vec,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + OUT_W'(vec[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dest_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : dest_scoreboard
//  Description : Destination-register decoder with busy scoreboard. Decodes
//                the issuing op's destination to a one-hot write-enable,
//                tracks pending writes, stalls issue on RAW/WAW hazards and
//                clears busy bits from WB_PORTS writeback ports.
//  Ports       : clk          in   rising-edge clock
//                reset        in   asynchronous active-high reset
//                issueValid   in   issue request present
//                issueDest    in   destination register of issuing op
//                srcA, srcB   in   source registers of issuing op
//                issueReady   out  issue accepted this cycle (combinational)
//                wbValid      in   per-port writeback strobe
//                wbDest       in   per-port writeback register (packed)
//                decOut       out  one-hot write-enable of last accept (pulse)
//                busy         out  scoreboard, bit r = write to r pending
//                pendingCount out  popcount of busy
//                wbErr        out  sticky: writeback to a non-busy register
//  Revision    : 1.0  initial release
// ============================================================================
module dest_scoreboard
    import dest_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W_DEF,
    parameter int NREG     = 1 << ADDR_W,
    parameter int WB_PORTS = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issueValid,
    input  logic [ADDR_W-1:0]          issueDest,
    input  logic [ADDR_W-1:0]          srcA,
    input  logic [ADDR_W-1:0]          srcB,
    output logic                       issueReady,
    input  logic [WB_PORTS-1:0]        wbValid,
    input  logic [WB_PORTS*ADDR_W-1:0] wbDest,
    output logic [NREG-1:0]            decOut,
    output logic [NREG-1:0]            busy,
    output logic [ADDR_W:0]            pendingCount,
    output logic                       wbErr
);

    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   r_dec;
    logic [ADDR_W:0]   r_count;
    logic              r_wb_err;

    logic              w_ready;
    logic              w_accept;
    logic [NREG-1:0]   w_dec;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic              w_wb_err;
    logic [NREG-1:0]   w_busy_next;
    logic [ADDR_W:0]   w_count_next;

    // Hazard check looks at registered busy only: a writeback landing this
    // cycle does not unblock an issue until the following cycle.
    assign w_ready  = !(r_busy[srcA] | r_busy[srcB] | r_busy[issueDest]);
    assign w_accept = issueValid & w_ready;

    assign w_dec = NREG'(onehot_dec(c_MAX_ADDR_W'(issueDest)));

    // decOut still pulses bit 0 for a hardwired zero register; only the
    // busy set is suppressed.
    always_comb begin
        w_set = w_accept ? w_dec : '0;
        if (ZERO_REG != 0) begin
            w_set[0] = 1'b0;
        end
    end

    // Ports naming the same register simply OR into the clear mask.
    always_comb begin
        w_clr    = '0;
        w_wb_err = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wbValid[p] &&
                !((ZERO_REG != 0) && (wbDest[p*ADDR_W +: ADDR_W] == '0))) begin
                w_clr[wbDest[p*ADDR_W +: ADDR_W]] = 1'b1;
                if (!r_busy[wbDest[p*ADDR_W +: ADDR_W]]) begin
                    w_wb_err = 1'b1;
                end
            end
        end
    end

    // Set is applied after clear so an (illegal) same-register accept and
    // writeback leaves the register busy.
    assign w_busy_next = (r_busy & ~w_clr) | w_set;

    popcount_nreg #(
        .N     (NREG),
        .OUT_W (ADDR_W + 1)
    ) u_popcount (
        .vec   (w_busy_next),
        .count (w_count_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= '0;
            r_dec    <= '0;
            r_count  <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_busy  <= w_busy_next;
            r_dec   <= w_accept ? w_dec : '0;
            r_count <= w_count_next;
            if (w_wb_err) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign issueReady   = w_ready;
    assign decOut       = r_dec;
    assign busy         = r_busy;
    assign pendingCount = r_count;
    assign wbErr        = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_dest_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dest_scoreboard
//  Description : Self-checking bench for dest_scoreboard. One instance with
//                ZERO_REG=0 and one with ZERO_REG=1. Expected decOut pulses
//                are queued at issue time and popped by per-instance
//                monitors; state checks use hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dest_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // instance 0 (ZERO_REG = 0)
    logic        issueValid = 1'b0;
    logic [3:0]  issueDest = '0, srcA = '0, srcB = '0;
    logic        issueReady;
    logic [1:0]  wbValid = '0;
    logic [7:0]  wbDest = '0;
    logic [15:0] decOut, busy;
    logic [4:0]  pendingCount;
    logic        wbErr;

    // instance 1 (ZERO_REG = 1)
    logic        iv1 = 1'b0;
    logic [3:0]  id1 = '0, sa1 = '0, sb1 = '0;
    logic        rdy1;
    logic [1:0]  wv1 = '0;
    logic [7:0]  wd1 = '0;
    logic [15:0] dec1, busy1;
    logic [4:0]  cnt1;
    logic        err1;

    int total = 0;
    int bad   = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    dest_scoreboard #(.ADDR_W(4), .NREG(16), .WB_PORTS(2), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset),
        .issueValid(issueValid), .issueDest(issueDest), .srcA(srcA), .srcB(srcB),
        .issueReady(issueReady), .wbValid(wbValid), .wbDest(wbDest),
        .decOut(decOut), .busy(busy), .pendingCount(pendingCount), .wbErr(wbErr)
    );

    dest_scoreboard #(.ADDR_W(4), .NREG(16), .WB_PORTS(2), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset),
        .issueValid(iv1), .issueDest(id1), .srcA(sa1), .srcB(sb1),
        .issueReady(rdy1), .wbValid(wv1), .wbDest(wd1),
        .decOut(dec1), .busy(busy1), .pendingCount(cnt1), .wbErr(err1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge: apply inputs, check issueReady, queue the expected
    // pulse, and return at the next negedge with the edge's results visible.
    task automatic drive(input logic v, input logic [3:0] d, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] wv,
                         input logic [7:0] wd, input logic exp_rdy, input string nm);
        logic [15:0] oh;
        issueValid = v; issueDest = d; srcA = a; srcB = b;
        wbValid = wv; wbDest = wd;
        #1;
        if (v) begin
            chk({nm, "_ready"}, 32'(issueReady), 32'(exp_rdy));
            if (exp_rdy) begin
                oh = 16'h0001 << d;
                q0.push_back(oh);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive1(input logic v, input logic [3:0] d, input logic [1:0] wv,
                          input logic [7:0] wd, input logic exp_rdy, input string nm);
        logic [15:0] oh;
        iv1 = v; id1 = d; sa1 = 4'd0; sb1 = 4'd0; wv1 = wv; wd1 = wd;
        #1;
        if (v) begin
            chk({nm, "_ready"}, 32'(rdy1), 32'(exp_rdy));
            if (exp_rdy) begin
                oh = 16'h0001 << d;
                q1.push_back(oh);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 8'h00, 1'b0, "idle");
    endtask

    task automatic state(input string nm, input logic [15:0] eb, input logic [4:0] ec,
                         input logic ee);
        chk({nm, "_busy"}, 32'(busy), 32'(eb));
        chk({nm, "_count"}, 32'(pendingCount), 32'(ec));
        chk({nm, "_wberr"}, 32'(wbErr), 32'(ee));
    endtask

    // Monitors: every nonzero decOut must match the oldest queued issue.
    always @(negedge clk) begin
        if (!reset && decOut != 16'h0) begin
            if (q0.size() == 0) chk("dec0_unexpected", 32'(decOut), 32'h0);
            else                chk("dec0_pulse", 32'(decOut), 32'(q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!reset && dec1 != 16'h0) begin
            if (q1.size() == 0) chk("dec1_unexpected", 32'(dec1), 32'h0);
            else                chk("dec1_pulse", 32'(dec1), 32'(q1.pop_front()));
        end
    end

    initial begin
        // ---- power-on reset
        @(negedge clk);
        state("reset", 16'h0, 5'd0, 1'b0);
        chk("reset_dec", 32'(decOut), 32'h0);
        reset = 1'b0;

        // ---- asynchronous reset mid-operation
        drive(1, 4'd3, 4'd0, 4'd1, 2'b00, 8'h00, 1'b1, "iss3");
        drive(1, 4'd5, 4'd0, 4'd1, 2'b00, 8'h00, 1'b1, "iss5");
        issueValid = 1'b0;
        state("pre_reset", 16'h0028, 5'd2, 1'b0);
        chk("pre_reset_dec", 32'(decOut), 32'h0020);
        #2 reset = 1'b1;
        #1;
        state("async_reset", 16'h0, 5'd0, 1'b0);
        chk("async_reset_dec", 32'(decOut), 32'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        drive(1, 4'd3, 4'd0, 4'd1, 2'b00, 8'h00, 1'b1, "post_reset_iss3");
        state("post_reset", 16'h0008, 5'd1, 1'b0);
        drive(0, 4'd0, 4'd0, 4'd0, 2'b01, 8'h03, 1'b0, "wb3");
        state("wb3", 16'h0, 5'd0, 1'b0);

        // ---- basic issue and single-cycle pulse
        drive(1, 4'hA, 4'd1, 4'd2, 2'b00, 8'h00, 1'b1, "issA");
        state("issA", 16'h0400, 5'd1, 1'b0);
        chk("issA_dec", 32'(decOut), 32'h0400);
        idle();
        chk("issA_dec_gone", 32'(decOut), 32'h0);

        // ---- RAW stall with no same-cycle bypass
        drive(1, 4'd4, 4'd0, 4'd0, 2'b00, 8'h00, 1'b1, "iss4");
        state("iss4", 16'h0410, 5'd2, 1'b0);
        drive(1, 4'd8, 4'd4, 4'd0, 2'b01, 8'h04, 1'b0, "raw_stall");
        state("raw_wb4", 16'h0400, 5'd1, 1'b0);
        drive(1, 4'd8, 4'd4, 4'd0, 2'b00, 8'h00, 1'b1, "raw_go");
        state("raw_go", 16'h0500, 5'd2, 1'b0);
        // WAW: destination already pending
        drive(1, 4'd8, 4'd0, 4'd0, 2'b00, 8'h00, 1'b0, "waw_stall");
        drive(0, 4'd0, 4'd0, 4'd0, 2'b11, 8'h8A, 1'b0, "clrA8");
        state("clrA8", 16'h0, 5'd0, 1'b0);

        // ---- dual writeback
        drive(1, 4'd7, 4'd0, 4'd1, 2'b00, 8'h00, 1'b1, "iss7");
        drive(1, 4'd9, 4'd0, 4'd1, 2'b00, 8'h00, 1'b1, "iss9");
        state("busy79", 16'h0280, 5'd2, 1'b0);
        drive(0, 4'd0, 4'd0, 4'd0, 2'b11, 8'h97, 1'b0, "wb97");
        state("wb97", 16'h0, 5'd0, 1'b0);
        drive(1, 4'd7, 4'd0, 4'd1, 2'b00, 8'h00, 1'b1, "iss7b");
        // accept to 5 together with writeback of 7
        drive(1, 4'd5, 4'd0, 4'd1, 2'b01, 8'h07, 1'b1, "iss5_wb7");
        state("iss5_wb7", 16'h0020, 5'd1, 1'b0);
        drive(1, 4'd7, 4'd0, 4'd1, 2'b00, 8'h00, 1'b1, "iss7c");
        drive(0, 4'd0, 4'd0, 4'd0, 2'b11, 8'h55, 1'b0, "wb55");
        state("wb55", 16'h0080, 5'd1, 1'b0);
        drive(0, 4'd0, 4'd0, 4'd0, 2'b11, 8'h77, 1'b0, "wb77");
        state("wb77", 16'h0, 5'd0, 1'b0);

        // ---- fill all registers
        for (int d = 0; d < 16; d++) begin
            drive(1, 4'(d), 4'(d), 4'(d), 2'b00, 8'h00, 1'b1, "fill");
            if (d == 7) state("fill_half", 16'h00FF, 5'd8, 1'b0);
        end
        state("full", 16'hFFFF, 5'b10000, 1'b0);
        drive(1, 4'd0, 4'd1, 4'd2, 2'b00, 8'h00, 1'b0, "full_stall");
        state("full_hold", 16'hFFFF, 5'b10000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 4'd0, 4'd0, 4'd0, 2'b11, {4'(2*k+1), 4'(2*k)}, 1'b0, "drain");
        end
        state("drained", 16'h0, 5'd0, 1'b0);

        // ---- ZERO_REG=1 instance
        drive1(1, 4'd0, 2'b00, 8'h00, 1'b1, "z_iss0");
        chk("z_busy", 32'(busy1), 32'h0);
        chk("z_count", 32'(cnt1), 32'h0);
        chk("z_dec", 32'(dec1), 32'h0001);
        drive1(1, 4'd0, 2'b01, 8'h00, 1'b1, "z_iss0_wb0");
        chk("z_wberr", 32'(err1), 32'h0);
        chk("z_busy2", 32'(busy1), 32'h0);
        drive1(0, 4'd0, 2'b00, 8'h00, 1'b0, "z_idle");
        chk("z_dec_gone", 32'(dec1), 32'h0);

        // ---- sticky writeback error (ZERO_REG=0)
        drive(0, 4'd0, 4'd0, 4'd0, 2'b01, 8'h06, 1'b0, "wb_idle6");
        state("wberr_set", 16'h0, 5'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("wberr_sticky", 32'(wbErr), 32'h1);
        end
        // illegal same-register accept + writeback: set wins
        drive(1, 4'd2, 4'd0, 4'd0, 2'b01, 8'h02, 1'b1, "set_wins");
        state("set_wins", 16'h0004, 5'd1, 1'b1);

        idle();
        idle();
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
